serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 75 +++++++
 tb/tb_serial_adder.sv | 102 ++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder producing {C,S} = A + B + CIN, one bit per clock, LSB first
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CIN,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] S,
    output logic             C
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
    state_t           state;
    logic [WIDTH-1:0] a_sr, b_sr, sum_sr, sum_next;
    logic [CW-1:0]    cnt;
    logic             carry, hs, hc, sum_bit, cc, cout;
    assign hs       = a_sr[0] ^ b_sr[0];
    assign hc       = a_sr[0] & b_sr[0];
    assign sum_bit  = hs ^ carry;
    assign cc       = hs & carry;
    assign cout     = hc | cc;
    assign sum_next = {sum_bit, sum_sr[WIDTH-1:1]};
    // control FSM and datapath; FIN accepts START just like IDLE for back-to-back adds
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            BUSY   <= 1'b0;
            DONE   <= 1'b0;
            S      <= '0;
            C      <= 1'b0;
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    sum_sr <= sum_next;
                    carry  <= cout;
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        S     <= sum_next;
                        C     <= cout;
                        state <= FIN;
                        BUSY  <= 1'b0;
                        DONE  <= 1'b1;
                    end
                end
                default: begin
                    DONE <= 1'b0;
                    if (START) begin
                        a_sr   <= A;
                        b_sr   <= B;
                        sum_sr <= '0;
                        carry  <= CIN;
                        cnt    <= '0;
                        state  <= RUN;
                        BUSY   <= 1'b1;
                    end else begin
                        state <= IDLE;
                        BUSY  <= 1'b0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed and random checks of latency, handshake and sums for serial_adder
module tb_serial_adder;
    logic       clk, rst, START, CIN, BUSY, DONE, C;
    logic [7:0] A, B, S;
    logic [7:0] last_s;
    logic       last_c;
    int         n_chk, n_bad;

    serial_adder #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .START(START), .A(A), .B(B), .CIN(CIN),
        .BUSY(BUSY), .DONE(DONE), .S(S), .C(C)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // entered and left at 1 time unit after a rising edge
    task automatic op(input logic [7:0] a, input logic [7:0] b, input logic ci, input int gap, input bit hold);
        logic [8:0] e;
        e = {1'b0, a} + {1'b0, b} + {8'd0, ci};
        for (int g = 0; g < gap; g++) begin
            @(posedge clk); #1;
            chk("idle_done", 32'(DONE), 0);
            chk("idle_s", 32'(S), 32'(last_s));
        end
        START = 1'b1; A = a; B = b; CIN = ci;
        @(posedge clk); #1;
        START = hold; A = ~a; B = ~b; CIN = ~ci;
        chk("busy_e0", 32'(BUSY), 1);
        chk("done_e0", 32'(DONE), 0);
        for (int i = 1; i < 8; i++) begin
            @(posedge clk); #1;
            chk("busy_run", 32'(BUSY), 1);
            chk("done_run", 32'(DONE), 0);
            chk("s_hold", 32'(S), 32'(last_s));
            chk("c_hold", 32'(C), 32'(last_c));
        end
        @(posedge clk); #1;
        chk("done_fin", 32'(DONE), 1);
        chk("busy_fin", 32'(BUSY), 0);
        chk("sum", 32'(S), 32'(e[7:0]));
        chk("carry", 32'(C), 32'(e[8]));
        last_s = e[7:0];
        last_c = e[8];
    endtask

    initial begin
        n_chk = 0; n_bad = 0;
        last_s = 8'h00; last_c = 1'b0;
        rst = 1'b1; START = 1'b0; A = 8'h00; B = 8'h00; CIN = 1'b0;
        #1;
        chk("rst_busy", 32'(BUSY), 0);
        chk("rst_done", 32'(DONE), 0);
        chk("rst_s", 32'(S), 0);
        chk("rst_c", 32'(C), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        op(8'h7F, 8'h01, 1'b0, 1, 1'b0);
        op(8'hFF, 8'h01, 1'b0, 2, 1'b0);
        op(8'h5A, 8'hA5, 1'b1, 1, 1'b0);
        op(8'h00, 8'h00, 1'b0, 1, 1'b0);
        op(8'hFF, 8'hFF, 1'b1, 1, 1'b0);
        op(8'h33, 8'h44, 1'b0, 1, 1'b1);
        op(8'h12, 8'h34, 1'b1, 0, 1'b0);
        op(8'h80, 8'h80, 1'b0, 0, 1'b0);
        // abort mid-run: asynchronous clear, START blocked during reset, no DONE afterwards
        @(posedge clk); #1;
        START = 1'b1; A = 8'hC3; B = 8'h3C; CIN = 1'b1;
        @(posedge clk); #1;
        START = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", 32'(BUSY), 0);
        chk("abort_done", 32'(DONE), 0);
        chk("abort_s", 32'(S), 0);
        chk("abort_c", 32'(C), 0);
        START = 1'b1;
        @(posedge clk); #1;
        chk("rst_start_busy", 32'(BUSY), 0);
        START = 1'b0; rst = 1'b0;
        last_s = 8'h00; last_c = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            chk("post_rst_done", 32'(DONE), 0);
            chk("post_rst_busy", 32'(BUSY), 0);
        end
        op(8'h10, 8'h20, 1'b0, 0, 1'b0);
        for (int k = 0; k < 1000; k++)
            op(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 1'b0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
